rf_writeback_unit: RTL and testbench

- Writer side of the 32x32 integer register file.
- Collects results from the single-cycle ALU path and the variable-latency load path. Formats load data by size and sign. Arbitrates between the two sources.
- Drives the register file write port (waddr/wdata/wen) from registers, one write per cycle.
- Exposes the committed write as a bypass for decode.

---
 rtl/rf_writeback_unit.sv | 147 ++++++++++++++
 tb/tb_rf_writeback_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_unit.sv
// Register file writer: merges single-cycle ALU results with buffered, pre-formatted
// load responses and drives one registered write per cycle (also exported as bypass).
module rf_writeback_unit #(
   parameter int LD_FIFO_DEPTH = 2,
   parameter int AGE_MAX       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_rdata,
   output logic        ld_err,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        rf_wen,
   output logic        byp_valid,
   output logic [4:0]  byp_addr,
   output logic [31:0] byp_data
);

   localparam int PW = $clog2(LD_FIFO_DEPTH);
   localparam int CW = $clog2(LD_FIFO_DEPTH + 1);
   localparam int AW = $clog2(AGE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(LD_FIFO_DEPTH);
   localparam logic [AW-1:0] AGE_LIM  = AW'(AGE_MAX);

   // Illegal load encodings are still written, formatted as a full word.
   function automatic logic load_illegal(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_illegal = 1'b0;
         default:                                load_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                            input logic [1:0]  lo,
                                            input logic [31:0] w);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] b_ext;
      logic signed [31:0] h_ext;
      b     = w[{lo, 3'b000} +: 8];
      h     = lo[1] ? w[31:16] : w[15:0];
      b_ext = 32'(b);
      h_ext = 32'(h);
      case (f3)
         3'b000:  fmt_load = b_ext;
         3'b001:  fmt_load = h_ext;
         3'b100:  fmt_load = {24'd0, b};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = w;
      endcase
   endfunction

   logic [4:0]    fifo_rd   [LD_FIFO_DEPTH];
   logic [31:0]   fifo_data [LD_FIFO_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic [AW-1:0] age;

   logic          empty;
   logic          full;
   logic          force_ld;
   logic          alu_sel;
   logic          pop;
   logic          push;
   logic [31:0]   ld_fmt_p0;

   logic [4:0]    waddr_p1;
   logic [31:0]   wdata_p1;
   logic          vld_p1;
   logic          err_p1;

   // Stage p0: handshake, arbitration and load formatting
   always_comb begin
      empty     = (count == '0);
      full      = (count == FULL_CNT);
      force_ld  = !empty && (full || age == AGE_LIM);
      alu_sel   = alu_valid && !force_ld;
      pop       = !alu_sel && !empty;
      push      = ld_valid && !full;
      ld_fmt_p0 = fmt_load(ld_funct3, ld_addr_lo, ld_rdata);
   end

   assign alu_ready = !force_ld;
   assign ld_ready  = !full;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wptr]   <= ld_rd;
         fifo_data[wptr] <= ld_fmt_p0;
      end
   end

   // Stage p1: registered write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         age      <= '0;
         err_p1   <= 1'b0;
         vld_p1   <= 1'b0;
         waddr_p1 <= '0;
         wdata_p1 <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (empty || pop)      age <= '0;
         else if (age != AGE_LIM) age <= age + AW'(1);
         err_p1 <= push && load_illegal(ld_funct3);
         if (alu_sel) begin
            waddr_p1 <= alu_rd;
            wdata_p1 <= alu_data;
            vld_p1   <= (alu_rd != 5'd0);
         end else if (pop) begin
            waddr_p1 <= fifo_rd[rptr];
            wdata_p1 <= fifo_data[rptr];
            vld_p1   <= (fifo_rd[rptr] != 5'd0);
         end else begin
            vld_p1   <= 1'b0;
         end
      end
   end

   assign rf_waddr  = waddr_p1;
   assign rf_wdata  = wdata_p1;
   assign rf_wen    = vld_p1;
   assign ld_err    = err_p1;
   assign byp_valid = vld_p1;
   assign byp_addr  = waddr_p1;
   assign byp_data  = wdata_p1;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Bench for rf_writeback_unit: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rf_writeback_unit;

   localparam int DEPTH = 2;
   localparam int AMAX  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [4:0]  ld_rd = '0;
   logic [2:0]  ld_funct3 = '0;
   logic [1:0]  ld_addr_lo = '0;
   logic [31:0] ld_rdata = '0;
   logic        ld_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_wen;
   logic        byp_valid;
   logic [4:0]  byp_addr;
   logic [31:0] byp_data;

   rf_writeback_unit #(.LD_FIFO_DEPTH(DEPTH), .AGE_MAX(AMAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
      .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata), .ld_err(ld_err),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
      .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model: a queue of formatted loads and an age count
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   int          age;
   logic        m_wen;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_err;

   function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
      logic [31:0] v;
      case (f3)
         3'b000, 3'b100: begin
            v = (w >> (8 * lo)) & 32'h0000_00FF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
         end
         3'b001, 3'b101: begin
            v = (w >> (16 * lo[1])) & 32'h0000_FFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic bit m_force();
      return (q.size() > 0) && (q.size() == DEPTH || age == AMAX);
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int   n;
      bit   f;
      bit   popped;
      ent_t e;
      if (rst) begin
         q.delete();
         age    = 0;
         m_wen  = 1'b0;
         m_addr = '0;
         m_data = '0;
         m_err  = 1'b0;
      end else begin
         n      = q.size();
         f      = m_force();
         popped = 1'b0;
         if (alu_valid && !f) begin
            m_wen  = (alu_rd != 5'd0);
            m_addr = alu_rd;
            m_data = alu_data;
         end else if (n > 0) begin
            e      = q.pop_front();
            m_wen  = (e.rd != 5'd0);
            m_addr = e.rd;
            m_data = e.d;
            popped = 1'b1;
         end else begin
            m_wen  = 1'b0;
         end
         if (n == 0 || popped) age = 0;
         else if (age < AMAX)  age = age + 1;
         m_err = 1'b0;
         if (ld_valid && n < DEPTH) begin
            e.rd = ld_rd;
            e.d  = ref_fmt(ld_funct3, ld_addr_lo, ld_rdata);
            q.push_back(e);
            m_err = !(ld_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
         end
      end
   end

   always @(negedge clk) begin
      chk("alu_ready", 32'(alu_ready), 32'(!m_force()));
      chk("ld_ready",  32'(ld_ready),  32'(q.size() < DEPTH));
      chk("rf_wen",    32'(rf_wen),    32'(m_wen));
      chk("rf_waddr",  32'(rf_waddr),  32'(m_addr));
      chk("rf_wdata",  rf_wdata,       m_data);
      chk("ld_err",    32'(ld_err),    32'(m_err));
      chk("byp",       {byp_data[26:0], byp_addr},  {rf_wdata[26:0], rf_waddr});
      chk("byp_valid", 32'(byp_valid), 32'(rf_wen));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
   endtask

   task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] w,
                          input logic [31:0] exp, input logic err);
      ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo; ld_rdata = w;
      chk({nm, "_ready"}, 32'(ld_ready), 32'd1);
      step();
      ld_valid = 1'b0;
      chk({nm, "_err"}, 32'(ld_err), 32'(err));
      chk({nm, "_wen_n1"}, 32'(rf_wen), 32'd0);
      step();
      chk({nm, "_wen_n2"}, 32'(rf_wen), 32'd1);
      chk({nm, "_waddr"}, 32'(rf_waddr), 32'(rd));
      chk({nm, "_wdata"}, rf_wdata, exp);
      chk({nm, "_err_off"}, 32'(ld_err), 32'd0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int ai;
      bit acc;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wen",   32'(rf_wen),   32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata,      32'd0);
      chk("rst_err",   32'(ld_err),   32'd0);
      rst = 1'b0;
      step();

      // Single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      step();
      alu_valid = 1'b0;
      chk("alu_wen",   32'(rf_wen),    32'd1);
      chk("alu_waddr", 32'(rf_waddr),  32'd5);
      chk("alu_wdata", rf_wdata,       32'hDEAD_BEEF);
      chk("alu_byp",   32'(byp_valid), 32'd1);
      step();
      chk("alu_wen_off", 32'(rf_wen), 32'd0);

      // Load formatting
      do_load("lb2",  5'd3, 3'b000, 2'd2, 32'h12F4_5678, 32'hFFFF_FFF4, 1'b0);
      do_load("lhu2", 5'd4, 3'b101, 2'd2, 32'h12F4_5678, 32'h0000_12F4, 1'b0);
      do_load("lh0",  5'd6, 3'b001, 2'd0, 32'h12F4_5678, 32'h0000_5678, 1'b0);
      do_load("f011", 5'd8, 3'b011, 2'd1, 32'h12F4_5678, 32'h12F4_5678, 1'b1);
      do_load("lbu1", 5'd9, 3'b100, 2'd1, 32'h8765_A3C1, 32'h0000_00A3, 1'b0);
      do_load("lh3",  5'd10, 3'b001, 2'd3, 32'h8765_A3C1, 32'hFFFF_8765, 1'b0);
      do_load("lw3",  5'd11, 3'b010, 2'd3, 32'h8765_A3C1, 32'h8765_A3C1, 1'b0);

      // Writes to x0 are accepted and dropped
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
      chk("x0_alu_ready", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
      chk("x0_alu_wen", 32'(rf_wen), 32'd0);
      ld_valid = 1'b1; ld_rd = 5'd0; ld_funct3 = 3'b010; ld_rdata = 32'h5555_AAAA;
      chk("x0_ld_ready", 32'(ld_ready), 32'd1);
      step();
      ld_valid = 1'b0;
      step();
      chk("x0_ld_wen", 32'(rf_wen), 32'd0);
      step();

      // Contention: one load against continuous ALU traffic
      ai = 0;
      for (int c = 0; c < 10; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + ai); alu_data = 32'h100 + 32'(ai);
         ld_valid = (c == 0); ld_rd = 5'd7; ld_funct3 = 3'b010; ld_rdata = 32'hCAFE_0007;
         if (c >= 1 && c <= 5) begin
            chk("cont_alu_wen",   32'(rf_wen),   32'd1);
            chk("cont_alu_waddr", 32'(rf_waddr), 32'(10 + c - 1));
         end
         if (c == 5) chk("cont_alu_ready_lo", 32'(alu_ready), 32'd0);
         if (c == 6) begin
            chk("cont_ld_waddr", 32'(rf_waddr), 32'd7);
            chk("cont_ld_wdata", rf_wdata,      32'hCAFE_0007);
            chk("cont_alu_ready_hi", 32'(alu_ready), 32'd1);
         end
         if (c == 7) chk("cont_resume_waddr", 32'(rf_waddr), 32'd15);
         acc = alu_ready;
         step();
         if (acc) ai++;
      end
      idle();
      repeat (8) step();

      // Full FIFO: two back-to-back loads under ALU pressure
      ai = 0;
      for (int c = 0; c < 12; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(1 + ai); alu_data = 32'hA000 + 32'(ai);
         ld_valid = (c < 2); ld_rd = (c == 0) ? 5'd20 : 5'd21;
         ld_funct3 = 3'b000; ld_addr_lo = 2'd0; ld_rdata = 32'h80 + 32'(c);
         if (c == 2) begin
            chk("full_ld_ready",  32'(ld_ready),  32'd0);
            chk("full_alu_ready", 32'(alu_ready), 32'd0);
         end
         if (c == 3) begin
            chk("full_ld_ready_back", 32'(ld_ready), 32'd1);
            chk("full_pop_waddr", 32'(rf_waddr), 32'd20);
            chk("full_pop_wdata", rf_wdata,      32'hFFFF_FF80);
         end
         acc = alu_ready;
         step();
         if (acc) ai++;
      end
      idle();
      repeat (8) step();

      // Asynchronous reset with two loads buffered
      for (int c = 0; c < 3; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(25 + c); alu_data = 32'hB000 + 32'(c);
         ld_valid = (c < 2); ld_rd = 5'(28 + c); ld_funct3 = 3'b010; ld_rdata = 32'hBAD0_0000;
         if (c < 2) step();
      end
      chk("rst_buffered", 32'(ld_ready), 32'd0);
      #3 rst = 1'b1;
      #1;
      chk("arst_wen",   32'(rf_wen),   32'd0);
      chk("arst_ready", 32'(ld_ready), 32'd1);
      idle();
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("arst_no_stale", 32'(rf_wen), 32'd0);
      end

      alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 32'h0BAD_F00D;
      step();
      idle();
      chk("post_rst_waddr", 32'(rf_waddr), 32'd31);
      chk("post_rst_wdata", rf_wdata,      32'h0BAD_F00D);
      repeat (2) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
